// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, sequencer states, constants.
// Used by both the command sequencer and the ALU itself.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  function automatic logic is_div0(
    input logic [1:0] op,
    input logic [7:0] b
  );
    return (op == OP_DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the 8-bit ALU: drives operands for a fixed
// latency, samples the result into an accumulator, returns it by handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_use_acc,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             acc_clr,
  output logic             alu_en,
  output logic [1:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_err,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  seq_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic [7:0]       opa;

  // A clear coinciding with acceptance zeroes the accumulator operand too
  assign opa = cmd_use_acc ? (acc_clr ? 8'h00 : acc_q) : cmd_a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    err_d   = err_q;
    acc_d   = acc_q;
    ops_d   = ops_q;
    unique case (state_q)
      IDLE: begin
        if (acc_clr) acc_d = 8'h00;
        if (cmd_valid) begin
          if (is_div0(cmd_op, cmd_b)) begin
            data_d  = DIV0_RESULT;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            op_d    = cmd_op;
            a_d     = opa;
            b_d     = cmd_b;
            en_d    = 1'b1;
            cnt_d   = 4'(ALU_LAT);
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d  = alu_f;
          acc_d   = alu_f;
          err_d   = 1'b0;
          en_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          ops_d   = ops_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      ops_q   <= ops_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == RESP);
  assign alu_en    = en_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = data_q;
  assign res_err   = err_q;
  assign acc       = acc_q;
  assign op_count  = ops_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (ALU_LAT 1 and 3), each with
// a reference ALU, directed commands and a scoreboard monitor.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n       [2];
  logic        cmd_valid   [2];
  logic        cmd_ready   [2];
  logic [1:0]  cmd_op      [2];
  logic        cmd_use_acc [2];
  logic [7:0]  cmd_a       [2];
  logic [7:0]  cmd_b       [2];
  logic        acc_clr     [2];
  logic        alu_en      [2];
  logic [1:0]  alu_op      [2];
  logic [7:0]  alu_a       [2];
  logic [7:0]  alu_b       [2];
  logic [7:0]  alu_f       [2];
  logic        res_valid   [2];
  logic        res_ready   [2];
  logic [7:0]  res_data    [2];
  logic        res_err     [2];
  logic [7:0]  acc         [2];
  logic [15:0] op_count    [2];

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic [7:0] a;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ops_seen[2];
  int   n_pass;
  int   n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] f_comb;
    logic [7:0] pipe [0:13];

    alu_cmd_sequencer #(.ALU_LAT(L), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_op     (cmd_op[g]),
      .cmd_use_acc(cmd_use_acc[g]),
      .cmd_a      (cmd_a[g]),
      .cmd_b      (cmd_b[g]),
      .acc_clr    (acc_clr[g]),
      .alu_en     (alu_en[g]),
      .alu_op     (alu_op[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_f      (alu_f[g]),
      .res_valid  (res_valid[g]),
      .res_ready  (res_ready[g]),
      .res_data   (res_data[g]),
      .res_err    (res_err[g]),
      .acc        (acc[g]),
      .op_count   (op_count[g])
    );

    // Reference ALU; extra register stages model a pipelined instance
    always_comb begin
      logic [15:0] p;
      p = 16'(alu_a[g]) * 16'(alu_b[g]);
      f_comb = 8'h00;
      case (alu_op[g])
        OP_ADD: f_comb = alu_a[g] + alu_b[g];
        OP_SUB: f_comb = alu_a[g] - alu_b[g];
        OP_MUL: f_comb = p[7:0];
        default: f_comb = (alu_b[g] == 8'h00) ? 8'hFF : alu_a[g] / alu_b[g];
      endcase
    end

    always @(posedge clk) begin
      pipe[0] <= f_comb;
      for (int i = 1; i < 14; i++) pipe[i] <= pipe[i-1];
    end

    if (L == 1) begin : g_comb
      assign alu_f[g] = f_comb;
    end else begin : g_pipe
      assign alu_f[g] = pipe[L-2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: compares whatever the DUT presents on res_*
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      exp_t e;
      int   sz;
      sz = (g == 0) ? q0.size() : q1.size();
      if (!rst_n[g]) begin
        ops_seen[g] = 0;
        if (g == 0) q0.delete();
        else q1.delete();
      end else if (res_valid[g]) begin
        if (sz == 0) begin
          chk($sformatf("unexpected_result%0d", g), 32'd1, 32'd0);
        end else begin
          e = (g == 0) ? q0[0] : q1[0];
          chk($sformatf("res_data%0d", g), 32'(res_data[g]), 32'(e.d));
          chk($sformatf("res_err%0d", g), 32'(res_err[g]), 32'(e.e));
          if (res_ready[g]) begin
            chk($sformatf("acc_at_hs%0d", g), 32'(acc[g]), 32'(e.a));
            chk($sformatf("op_count%0d", g), 32'(op_count[g]), 32'(ops_seen[g]));
            ops_seen[g]++;
            if (g == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
          end
        end
      end
    end
  end

  task automatic run_cmd(
    input int         g,
    input logic [1:0] op,
    input logic       ua,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       clr,
    input logic       clr_drive,
    input logic [7:0] ed,
    input logic       ee,
    input logic [7:0] ea,
    input int         lat,
    input int         en_cyc,
    input int         hold
  );
    exp_t e;
    int   j;
    int   en_n;
    @(posedge clk); #1;
    chk("cmd_ready_idle", 32'(cmd_ready[g]), 32'd1);
    cmd_valid[g]   = 1'b1;
    cmd_op[g]      = op;
    cmd_use_acc[g] = ua;
    cmd_a[g]       = a;
    cmd_b[g]       = b;
    acc_clr[g]     = clr;
    res_ready[g]   = (hold == 0);
    e.d = ed;
    e.e = ee;
    e.a = ea;
    if (g == 0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge clk); #1;
    cmd_valid[g] = 1'b0;
    acc_clr[g]   = clr_drive;
    j    = 1;
    en_n = 0;
    forever begin
      @(negedge clk);
      acc_clr[g] = 1'b0;
      if (alu_en[g]) en_n++;
      if (res_valid[g]) break;
      j++;
      if (j > 40) begin
        chk("res_valid_timeout", 32'd1, 32'd0);
        break;
      end
    end
    chk("latency", 32'(j), 32'(lat));
    chk("alu_en_cycles", 32'(en_n), 32'(en_cyc));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("bp_res_valid", 32'(res_valid[g]), 32'd1);
        chk("bp_cmd_ready", 32'(cmd_ready[g]), 32'd0);
      end
      @(posedge clk); #1;
      res_ready[g] = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("post_res_valid", 32'(res_valid[g]), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready[g]), 32'd1);
    chk("post_acc", 32'(acc[g]), 32'(ea));
  endtask

  task automatic chk_reset_vals(input int g);
    chk("rst_cmd_ready", 32'(cmd_ready[g]), 32'd1);
    chk("rst_alu_en", 32'(alu_en[g]), 32'd0);
    chk("rst_alu_ops", {14'd0, alu_op[g], alu_a[g], alu_b[g]}, 32'd0);
    chk("rst_res", {22'd0, res_valid[g], res_err[g], res_data[g]}, 32'd0);
    chk("rst_acc", 32'(acc[g]), 32'd0);
    chk("rst_op_count", 32'(op_count[g]), 32'd0);
  endtask

  initial begin
    int vcnt;
    n_pass  = 0;
    n_total = 0;
    for (int g = 0; g < 2; g++) begin
      rst_n[g]       = 1'b0;
      cmd_valid[g]   = 1'b0;
      cmd_op[g]      = 2'b00;
      cmd_use_acc[g] = 1'b0;
      cmd_a[g]       = 8'h00;
      cmd_b[g]       = 8'h00;
      acc_clr[g]     = 1'b0;
      res_ready[g]   = 1'b1;
      ops_seen[g]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // ALU_LAT=1 instance: add, accumulator chain, div0, clear on accept
    run_cmd(0, OP_ADD, 0, 8'h12, 8'h34, 0, 0, 8'h46, 0, 8'h46, 2, 1, 0);
    run_cmd(0, OP_SUB, 1, 8'hAA, 8'h50, 0, 0, 8'hF6, 0, 8'hF6, 2, 1, 0);
    run_cmd(0, OP_MUL, 1, 8'h00, 8'h02, 0, 0, 8'hEC, 0, 8'hEC, 2, 1, 0);
    run_cmd(0, OP_DIV, 0, 8'h20, 8'h00, 0, 0, 8'hFF, 1, 8'hEC, 1, 0, 0);
    run_cmd(0, OP_ADD, 1, 8'h77, 8'h05, 1, 0, 8'h05, 0, 8'h05, 2, 1, 0);
    chk("op_count0_final", 32'(op_count[0]), 32'd5);

    // ALU_LAT=3 instance: backpressure, clear ignored during DRIVE
    run_cmd(1, OP_DIV, 0, 8'h64, 8'h07, 0, 0, 8'h0E, 0, 8'h0E, 4, 3, 5);
    run_cmd(1, OP_ADD, 1, 8'h00, 8'h05, 0, 1, 8'h13, 0, 8'h13, 4, 3, 0);

    // Asynchronous reset in the middle of DRIVE
    @(posedge clk); #1;
    cmd_valid[1] = 1'b1;
    cmd_op[1]    = OP_MUL;
    cmd_use_acc[1] = 1'b0;
    cmd_a[1]     = 8'h03;
    cmd_b[1]     = 8'h04;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    chk("drive_alu_en", 32'(alu_en[1]), 32'd1);
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    #1;
    chk_reset_vals(1);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    vcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid[1]) vcnt++;
    end
    chk("no_res_after_rst", 32'(vcnt), 32'd0);
    chk("op_count_after_rst", 32'(op_count[1]), 32'd0);
    run_cmd(1, OP_ADD, 0, 8'h01, 8'h02, 0, 0, 8'h03, 0, 8'h03, 4, 3, 0);
    chk("op_count1_final", 32'(op_count[1]), 32'd1);

    chk("sb0_empty", 32'(q0.size()), 32'd0);
    chk("sb1_empty", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
